// File: rtl/montgomery_exp_if.sv
// Montgomery multiplier port bundle.
// The exponentiator (master) launches one multiplication with mm_start and
// holds mm_a/mm_b/mm_m until the multiplier (slave) answers with mm_done.
interface montgomery_exp_if #(
    parameter int N = 512
);
    logic         mm_start;
    logic [N-1:0] mm_a;
    logic [N-1:0] mm_b;
    logic [N-1:0] mm_m;
    logic [N-1:0] mm_result;
    logic         mm_done;

    modport master (
        output mm_start,
        output mm_a,
        output mm_b,
        output mm_m,
        input  mm_result,
        input  mm_done
    );

    modport slave (
        input  mm_start,
        input  mm_a,
        input  mm_b,
        input  mm_m,
        output mm_result,
        output mm_done
    );
endinterface

// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply modular exponentiation driving an
// external Montgomery multiplier. The base arrives already in the Montgomery
// domain; a final multiply by 1 brings the result back to the normal domain.
// Optional build macro SKIP_LEADING_ZEROS_EN: the SCAN state walks past the
// leading zero bits of the exponent without issuing any multiplication.
module montgomery_exp #(
    parameter int N      = 512,
    parameter int E_BITS = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [N-1:0]      in_x,
    input  logic [E_BITS-1:0] in_e,
    input  logic [N-1:0]      in_m,
    input  logic [N-1:0]      in_r,
    output logic [N-1:0]      result,
    output logic              done,
    output logic              busy,
    montgomery_exp_if.master  mm
);

    localparam int IW = (E_BITS > 1) ? $clog2(E_BITS) : 1;

    typedef enum logic [3:0] {
        IDLE,
        SCAN,
        SQR_ISSUE,
        SQR_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        POST_ISSUE,
        POST_WAIT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      x_q, x_d;
    logic [E_BITS-1:0] e_q, e_d;
    logic [N-1:0]      m_q, m_d;
    logic [N-1:0]      a_q, a_d;
    logic [IW-1:0]     i_q, i_d;
    logic [N-1:0]      result_q, result_d;

    // State and datapath registers; reset clears everything, which also
    // makes any multiplier completion still in flight harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            e_q      <= e_d;
            m_q      <= m_d;
            a_q      <= a_d;
            i_q      <= i_d;
            result_q <= result_d;
        end
    end

    // Next-state and multiplier operand selection; operands depend only on
    // the state and on A, which changes only on the mm_done edge, so they
    // stay stable for the whole issue..wait window.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        e_d         = e_q;
        m_d         = m_q;
        a_d         = a_q;
        i_d         = i_q;
        result_d    = result_q;
        mm.mm_start = 1'b0;
        mm.mm_a     = '0;
        mm.mm_b     = '0;
        mm.mm_m     = (state_q == IDLE) ? '0 : m_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = in_x;
                    e_d     = in_e;
                    m_d     = in_m;
                    a_d     = in_r;
                    i_d     = IW'(E_BITS - 1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef SKIP_LEADING_ZEROS_EN
                if (e_q[i_q]) begin
                    state_d = SQR_ISSUE;
                end else if (i_q == '0) begin
                    state_d = POST_ISSUE;
                end else begin
                    i_d = i_q - IW'(1);
                end
`else
                state_d = SQR_ISSUE;
`endif
            end
            SQR_ISSUE: begin
                mm.mm_start = 1'b1;
                mm.mm_a     = a_q;
                mm.mm_b     = a_q;
                state_d     = SQR_WAIT;
            end
            SQR_WAIT: begin
                mm.mm_a = a_q;
                mm.mm_b = a_q;
                if (mm.mm_done) begin
                    a_d = mm.mm_result;
                    if (e_q[i_q]) begin
                        state_d = MUL_ISSUE;
                    end else if (i_q == '0) begin
                        state_d = POST_ISSUE;
                    end else begin
                        i_d     = i_q - IW'(1);
                        state_d = SQR_ISSUE;
                    end
                end
            end
            MUL_ISSUE: begin
                mm.mm_start = 1'b1;
                mm.mm_a     = a_q;
                mm.mm_b     = x_q;
                state_d     = MUL_WAIT;
            end
            MUL_WAIT: begin
                mm.mm_a = a_q;
                mm.mm_b = x_q;
                if (mm.mm_done) begin
                    a_d = mm.mm_result;
                    if (i_q == '0) begin
                        state_d = POST_ISSUE;
                    end else begin
                        i_d     = i_q - IW'(1);
                        state_d = SQR_ISSUE;
                    end
                end
            end
            POST_ISSUE: begin
                mm.mm_start = 1'b1;
                mm.mm_a     = a_q;
                mm.mm_b     = N'(1);
                state_d     = POST_WAIT;
            end
            POST_WAIT: begin
                mm.mm_a = a_q;
                mm.mm_b = N'(1);
                if (mm.mm_done) begin
                    result_d = mm.mm_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign done   = (state_q == DONE);
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_montgomery_exp.sv
// Self-checking bench for montgomery_exp with a behavioural Montgomery
// multiplier (a*b*256^-1 mod M, completion 5 cycles after launch).
// Expected results come from a plain normal-domain modular exponentiation.
module tb_montgomery_exp;

   localparam int N      = 8;
   localparam int E_BITS = 8;
   localparam int MOD    = 13;

   logic              clk    = 1'b0;
   logic              reset  = 1'b1;
   logic              start  = 1'b0;
   logic [N-1:0]      in_x   = '0;
   logic [E_BITS-1:0] in_e   = '0;
   logic [N-1:0]      in_m   = '0;
   logic [N-1:0]      in_r   = '0;
   logic [N-1:0]      result;
   logic              done;
   logic              busy;

   montgomery_exp_if #(.N(N)) mmIf ();

   montgomery_exp #(.N(N), .E_BITS(E_BITS)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .in_x   (in_x),
      .in_e   (in_e),
      .in_m   (in_m),
      .in_r   (in_r),
      .result (result),
      .done   (done),
      .busy   (busy),
      .mm     (mmIf)
   );

   // Free-running clock
   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;
   int mmCount     = 0;
   int stabErrors  = 0;
   int cnt         = 0;
   logic chkWin    = 1'b0;
   logic injectSpur = 1'b0;
   logic [N-1:0] capA = '0;
   logic [N-1:0] capB = '0;
   logic [N-1:0] capM = '0;
   logic [N-1:0] pendRes = '0;
   int expQ[$];

   function automatic int montMul(int a, int b, int m);
      int rinv;
      rinv = 0;
      for (int k = 1; k < m; k++) begin
         if (((256 * k) % m) == 1) rinv = k;
      end
      return (((a * b) % m) * rinv) % m;
   endfunction

   function automatic int modExp(int x, int e, int m);
      int r;
      logic [E_BITS-1:0] eb;
      eb = E_BITS'(e);
      r  = 1 % m;
      for (int b = E_BITS - 1; b >= 0; b--) begin
         r = (r * r) % m;
         if (eb[b]) r = (r * x) % m;
      end
      return r;
   endfunction

   function automatic int expCount(int e);
      int pop;
      int msb;
      logic [E_BITS-1:0] eb;
      eb  = E_BITS'(e);
      pop = 0;
      msb = -1;
      for (int b = 0; b < E_BITS; b++) begin
         if (eb[b]) begin
            pop++;
            msb = b;
         end
      end
`ifdef SKIP_LEADING_ZEROS_EN
      if (msb < 0) return 1;
      return (msb + 1) + pop + 1;
`else
      return E_BITS + pop + 1;
`endif
   endfunction

   // Behavioural multiplier: launches on mm_start, answers after 5 cycles,
   // watches operand stability and can inject a stray mm_done on a squaring issue
   always @(negedge clk) begin
      mmIf.mm_done = 1'b0;
      if (reset) chkWin = 1'b0;
      if (cnt > 0) begin
         if (chkWin && (mmIf.mm_a !== capA || mmIf.mm_b !== capB || mmIf.mm_m !== capM))
            stabErrors++;
         cnt--;
         if (cnt == 0) begin
            mmIf.mm_done   = 1'b1;
            mmIf.mm_result = pendRes;
         end
      end
      if (mmIf.mm_start === 1'b1) begin
         mmCount++;
         capA    = mmIf.mm_a;
         capB    = mmIf.mm_b;
         capM    = mmIf.mm_m;
         pendRes = N'(montMul(int'(capA), int'(capB), int'(capM)));
         cnt     = 5;
         chkWin  = 1'b1;
         if (injectSpur && capA == capB) begin
            mmIf.mm_done   = 1'b1;
            mmIf.mm_result = 8'hA5;
         end
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int x, input int e);
      in_x  = N'((x * 256) % MOD);
      in_e  = E_BITS'(e);
      in_m  = N'(MOD);
      in_r  = N'(256 % MOD);
      expQ.push_back(modExp(x, e, MOD));
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string tag, input bit pulse);
      bit seen;
      int exp;
      seen = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (pulse) start = ((k % 7) == 3);
      end
      if (pulse) start = 1'b0;
      exp = (expQ.size() > 0) ? expQ.pop_front() : -1;
      if (!seen) checkOutput({tag, "_timeout"}, 0, 1);
      else       checkOutput({tag, "_result"}, int'(result), exp);
   endtask

   task automatic runOp(input string tag, input int x, input int e, input bit pulse, input bit spur);
      int snap;
      int stabSnap;
      snap       = mmCount;
      stabSnap   = stabErrors;
      injectSpur = spur;
      applyStimulus(x, e);
      checkOutput({tag, "_busy"}, int'(busy), 1);
      waitDone(tag, pulse);
      injectSpur = 1'b0;
      checkOutput({tag, "_mmcount"}, mmCount - snap, expCount(e));
      checkOutput({tag, "_stable"}, stabErrors - stabSnap, 0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_donePulse"}, int'(done), 0);
      checkOutput({tag, "_idle"}, int'(busy), 0);
   endtask

   // Directed sequence
   initial begin
      int snap;
      int stabSnap;
      bit gotIssue;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_result", int'(result), 0);
      checkOutput("rst_mmStart", int'(mmIf.mm_start), 0);
      checkOutput("rst_mmA", int'(mmIf.mm_a), 0);
      checkOutput("rst_mmB", int'(mmIf.mm_b), 0);
      checkOutput("rst_mmM", int'(mmIf.mm_m), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      runOp("e3", 2, 3, 1'b0, 1'b0);
      runOp("e0", 2, 0, 1'b0, 1'b0);
      runOp("e1", 2, 1, 1'b0, 1'b0);
      runOp("e255", 2, 255, 1'b0, 1'b0);
      runOp("x7e200", 7, 200, 1'b0, 1'b0);
      runOp("e3noise", 2, 3, 1'b1, 1'b1);

      // Reset while a squaring is outstanding
      applyStimulus(2, 3);
      gotIssue = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (mmIf.mm_start) begin
            gotIssue = 1'b1;
            break;
         end
      end
      checkOutput("midrst_issue", int'(gotIssue), 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      void'(expQ.pop_front());
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_done", int'(done), 0);
      checkOutput("midrst_mmStart", int'(mmIf.mm_start), 0);
      checkOutput("midrst_result", int'(result), 0);
      checkOutput("midrst_mmM", int'(mmIf.mm_m), 0);
      repeat (2) @(posedge clk);
      #1;
      runOp("afterRst", 2, 3, 1'b0, 1'b0);

      // Start held high: two back-to-back operations
      snap     = mmCount;
      stabSnap = stabErrors;
      in_x  = N'((3 * 256) % MOD);
      in_e  = E_BITS'(5);
      expQ.push_back(modExp(3, 5, MOD));
      expQ.push_back(modExp(3, 5, MOD));
      start = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("b2b1_busy", int'(busy), 1);
      waitDone("b2b1", 1'b0);
      checkOutput("b2b1_mmcount", mmCount - snap, expCount(5));
      snap = mmCount;
      @(posedge clk);
      #1;
      checkOutput("b2b_idleDone", int'(done), 0);
      checkOutput("b2b_idleBusy", int'(busy), 0);
      @(posedge clk);
      #1;
      checkOutput("b2b2_busy", int'(busy), 1);
      waitDone("b2b2", 1'b0);
      start = 1'b0;
      checkOutput("b2b2_mmcount", mmCount - snap, expCount(5));
      checkOutput("b2b_stable", stabErrors - stabSnap, 0);
      @(posedge clk);
      #1;
      checkOutput("b2b2_donePulse", int'(done), 0);
      checkOutput("b2b2_idle", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
